sprite_frame_loader: RTL and testbench
======================================

Name: sprite_frame_loader

Overview:
- Sprite frame store that sits behind the ship renderer.
- Loads up to 15 animation frames (80x80 pixels, 4-bit palette index) from a byte stream over a valid/ready handshake.
- Answers the renderer's 19-bit read_address with all 15 frame pixels in parallel, registered with 1-cycle latency.
- The renderer picks among data1..data15; this block drives those words on a packed bus.

Parameters:
- FRAME_PIXELS, 6400, pixels per frame (80*80); must be even.
- NUM_FRAMES, 15, number of frame banks.
- PIX_W, 4, bits per pixel (palette index).

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle request to begin loading a frame
- load_frame  input  4  target bank index, sampled with load_start
- load_abort  input  1  abandon current load
- in_data  input  8  two pixels per byte: [3:0] even pixel, [7:4] odd pixel
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- load_busy  output  1  high while a load is in progress
- load_done  output  1  one-cycle pulse on successful completion
- load_error  output  1  one-cycle pulse on rejected request (or checksum failure)
- read_address  input  19  pixel address from renderer, row-major, stride 80
- data_bus  output  60  frame k pixel in bits [4k+3:4k], k=0..14

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=0, load_busy=0, load_done=0, load_error=0, data_bus=0, FSM=IDLE, counters=0. Memory contents are not cleared.
- FSM states: IDLE, LOAD, CHECK (only with the feature), DONE.
- IDLE, load_start with load_frame<NUM_FRAMES: latch bank, wr_addr=0, go to LOAD.
- IDLE, load_start with load_frame>=NUM_FRAMES: load_error pulses 1 cycle; stay IDLE.
- LOAD outputs: in_ready=1, load_busy=1.
- LOAD beat (in_valid&&in_ready): write in_data[3:0] at wr_addr and in_data[7:4] at wr_addr+1 of the latched bank; wr_addr+=2.
- LOAD completion: the beat with wr_addr==FRAME_PIXELS-2 moves to DONE (or CHECK). Exactly FRAME_PIXELS/2=3200 beats per frame.
- LOAD: load_start is ignored.
- load_abort in LOAD/CHECK: next state IDLE, no done/error pulse. Already-written pixels stay written; the bank is partially updated.
- load_abort and an accepted beat in the same cycle: abort wins; the beat is not written.
- DONE: load_done=1 for one cycle, load_busy=0, then IDLE. A load_start in DONE is ignored.
- Read port, every cycle, independent of FSM: data_bus is registered from all 15 banks at read_address. Latency is exactly 1 cycle.
- read_address>=FRAME_PIXELS: the corresponding data_bus register loads 0 (transparent) for all banks. No aliasing; the full 19 bits are compared.
- Read/write collision (same bank, same address, same cycle): the read returns the old pixel (read-before-write).
- Reads of the bank being loaded are legal and return a mix of old and new content.
- Arithmetic: wr_addr is 13 bits, unsigned, never exceeds FRAME_PIXELS-1.
- Reset asserted mid-load: FSM=IDLE immediately; the bank keeps partial content.

Optional Feature:
- Macro: SPRITE_CHECKSUM_EN.
- When defined: an 8-bit modulo-256 sum of all 3200 accepted in_data bytes is accumulated. After the last pixel beat the FSM enters CHECK with in_ready=1 and accepts one more byte (checksum).
  - Equal: go to DONE (load_done pulse).
  - Unequal: load_error pulse 1 cycle, then IDLE; pixels stay written.
  - The accumulator clears on each accepted load_start.
- When not defined: no CHECK state and no accumulator. Completion goes straight to DONE after 3200 beats.

Test Plan:
- Reset state: Reset_n=0 for 3 cycles, then release. Require in_ready=0, load_busy=0, data_bus=0, no pulses.
- Full load: load_start, load_frame=2, then 3200 beats with in_data=8'h5A and in_valid=1. Require load_done pulse exactly 1 cycle after the last beat. Then read_address=0 gives data_bus[11:8]=4'hA one cycle later; read_address=1 gives 4'h5; read_address=6399 gives 4'h5.
- Backpressure/gaps: same load as above with in_valid toggled 1,0,0,1... Require exactly 3200 accepted beats before load_done and no extra writes.
- Bad index and abort:
  - load_frame=15: require load_error pulse and in_ready staying 0.
  - Load bank 0, abort after 100 beats: addresses 0..199 hold new data, address 200 holds old data, no load_done.
- Read bounds: read_address=6400 and 19'h7FFFF. Require data_bus=0 on the next cycle. Also a read collision at wr_addr returns the old pixel.
- SPRITE_CHECKSUM_EN: 3200 bytes of 8'h01 plus checksum 8'h80 (3200 mod 256=128) gives load_done. The same stream with checksum 8'h81 gives a load_error pulse and no load_done.

Source files
------------

// File: rtl/sprite_frame_loader_if.sv
// Bus bundle for the sprite frame loader.
// Groups the frame-load byte stream (start/abort, valid/ready, status pulses)
// and the renderer read port (pixel address in, all-bank pixel bus out).
// The loader connects to the slave modport; the load source and renderer
// side connect to the master modport.
interface sprite_frame_loader_if #(
  parameter int NUM_FRAMES = 15,
  parameter int PIX_W      = 4
);
  logic                        load_start;
  logic [3:0]                  load_frame;
  logic                        load_abort;
  logic [2*PIX_W-1:0]          in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        load_busy;
  logic                        load_done;
  logic                        load_error;
  logic [18:0]                 read_address;
  logic [NUM_FRAMES*PIX_W-1:0] data_bus;

  modport master (
    output load_start, load_frame, load_abort, in_data, in_valid, read_address,
    input  in_ready, load_busy, load_done, load_error, data_bus
  );

  modport slave (
    input  load_start, load_frame, load_abort, in_data, in_valid, read_address,
    output in_ready, load_busy, load_done, load_error, data_bus
  );
endinterface

// File: rtl/sprite_frame_loader.sv
// Sprite frame store behind the ship renderer.
// Holds NUM_FRAMES animation frames of FRAME_PIXELS 4-bit palette pixels.
// Frames are loaded two pixels per byte over a valid/ready stream; the
// renderer reads one pixel address and receives that pixel from every bank
// in parallel one cycle later. Addresses at or beyond FRAME_PIXELS read 0.
// Each bank is stored as FRAME_PIXELS/2 pixel-pair words so that one load
// beat is a single aligned word write.
// Optional feature macro: SPRITE_CHECKSUM_EN adds a trailing modulo-256
// checksum byte per frame, verified in a CHECK state before load_done.
module sprite_frame_loader #(
  parameter int FRAME_PIXELS = 6400,
  parameter int NUM_FRAMES   = 15,
  parameter int PIX_W        = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_frame_loader_if.slave bus
);

  localparam int                ADDR_W    = $clog2(FRAME_PIXELS);
  localparam int                WORDS     = FRAME_PIXELS / 2;
  localparam int                WORD_W    = 2 * PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 2);
  localparam logic [18:0]       RD_LIMIT  = 19'(FRAME_PIXELS);

`ifdef SPRITE_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_bank;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_load_error;

  logic                w_in_ready;
  logic                w_load_busy;
  logic                w_load_done;
  logic                w_wr_en;
  logic                w_start_ok;
  logic                w_err_set;
  logic                w_last_beat;

`ifdef SPRITE_CHECKSUM_EN
  logic [WORD_W-1:0]   r_csum;
`endif

  // Pixel storage and read pipeline
  logic [WORD_W-1:0]   r_mem [NUM_FRAMES][WORDS];
  logic [WORD_W-1:0]   r_rd_word [NUM_FRAMES];
  logic                r_rd_in_range;
  logic                r_rd_odd;
  logic                w_rd_in_range;
  logic [ADDR_W-2:0]   w_rd_idx;
  logic [NUM_FRAMES*PIX_W-1:0] w_data_bus;

  assign w_last_beat   = (r_wr_addr == LAST_ADDR);
  assign w_rd_in_range = (bus.read_address < RD_LIMIT);
  // Out-of-range addresses are masked at the output; park the index at 0 so
  // the array is never indexed past its end.
  assign w_rd_idx      = w_rd_in_range ? bus.read_address[ADDR_W-1:1] : '0;

  // FSM state register and load bookkeeping (bank, write address, checksum, error pulse)
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_bank       <= '0;
      r_wr_addr    <= '0;
      r_load_error <= 1'b0;
`ifdef SPRITE_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_load_error <= w_err_set;
      if (w_start_ok) begin
        r_bank    <= bus.load_frame;
        r_wr_addr <= '0;
`ifdef SPRITE_CHECKSUM_EN
        r_csum    <= '0;
`endif
      end else if (w_wr_en) begin
        // Wrap after the final pair so the address never leaves the frame.
        r_wr_addr <= w_last_beat ? '0 : r_wr_addr + ADDR_W'(2);
`ifdef SPRITE_CHECKSUM_EN
        r_csum    <= r_csum + bus.in_data;
`endif
      end
    end
  end

  // Next-state and handshake decode; abort always wins over a beat in flight
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_load_busy  = 1'b0;
    w_load_done  = 1'b0;
    w_wr_en      = 1'b0;
    w_start_ok   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_start) begin
          if (32'(bus.load_frame) < NUM_FRAMES) begin
            w_start_ok   = 1'b1;
            w_next_state = ST_LOAD;
          end else begin
            w_err_set    = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_in_ready  = 1'b1;
        w_load_busy = 1'b1;
        if (bus.load_abort) begin
          w_next_state = ST_IDLE;
        end else if (bus.in_valid) begin
          w_wr_en = 1'b1;
          if (w_last_beat) begin
`ifdef SPRITE_CHECKSUM_EN
            w_next_state = ST_CHECK;
`else
            w_next_state = ST_DONE;
`endif
          end
        end
      end
`ifdef SPRITE_CHECKSUM_EN
      ST_CHECK: begin
        w_in_ready  = 1'b1;
        w_load_busy = 1'b1;
        if (bus.load_abort) begin
          w_next_state = ST_IDLE;
        end else if (bus.in_valid) begin
          if (bus.in_data == r_csum) begin
            w_next_state = ST_DONE;
          end else begin
            w_err_set    = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
`endif
      ST_DONE: begin
        w_load_done  = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Frame memory: pair write from the load stream, per-bank read for the renderer.
  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_mem[r_bank][r_wr_addr[ADDR_W-1:1]] <= bus.in_data;
    end
    for (int k = 0; k < NUM_FRAMES; k++) begin
      r_rd_word[k] <= r_mem[k][w_rd_idx];
    end
  end

  // Read-side control: remembers range and pixel parity for the registered read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_in_range <= 1'b0;
      r_rd_odd      <= 1'b0;
    end else begin
      r_rd_in_range <= w_rd_in_range;
      r_rd_odd      <= bus.read_address[0];
    end
  end

  // Pick the addressed nibble of each bank's pair word, or 0 when out of range
  always_comb begin
    w_data_bus = '0;
    for (int k = 0; k < NUM_FRAMES; k++) begin
      if (r_rd_in_range) begin
        w_data_bus[k*PIX_W +: PIX_W] = r_rd_odd ? r_rd_word[k][WORD_W-1:PIX_W]
                                                : r_rd_word[k][PIX_W-1:0];
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.load_busy  = w_load_busy;
  assign bus.load_done  = w_load_done;
  assign bus.load_error = r_load_error;
  assign bus.data_bus   = w_data_bus;

endmodule

// File: tb/tb_sprite_frame_loader.sv
// Directed testbench for sprite_frame_loader.
// Scenarios: reset, bad bank index, full load, abort, read collision,
// backpressure with gaps, read bounds, reset mid-load and, when
// SPRITE_CHECKSUM_EN is defined, checksum pass/fail.
module tb_sprite_frame_loader;
  localparam int FP = 6400;
  localparam int NF = 15;
  localparam int PW = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sprite_frame_loader_if #(.NUM_FRAMES(NF), .PIX_W(PW)) u_if();

  sprite_frame_loader #(.FRAME_PIXELS(FP), .NUM_FRAMES(NF), .PIX_W(PW)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (u_if.slave)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic start_load(input logic [3:0] bank);
    u_if.load_start = 1'b1;
    u_if.load_frame = bank;
    step();
    u_if.load_start = 1'b0;
  endtask

  // Drives bytes until nbeats have been accepted (bounded). With gaps the
  // valid pattern is 1,0,0 and idle cycles carry 8'hFF so stray writes show.
  task automatic feed(input logic [7:0] b, input int nbeats, input bit gaps,
                      output int accepted, output int early, output logic [7:0] sum);
    int phase;
    int cycles;
    phase = 0; cycles = 0; accepted = 0; early = 0; sum = 8'h00;
    while (accepted < nbeats && cycles < 4 * nbeats + 10) begin
      u_if.in_valid = gaps ? (phase % 3 == 0) : 1'b1;
      u_if.in_data  = u_if.in_valid ? b : 8'hFF;
      phase++;
      if (u_if.load_done) early++;
      if (u_if.in_valid && u_if.in_ready) begin
        accepted++;
        sum = sum + b;
      end
      step();
      cycles++;
    end
    u_if.in_valid = 1'b0;
  endtask

  task automatic finish_csum(input logic [7:0] c);
`ifdef SPRITE_CHECKSUM_EN
    u_if.in_valid = 1'b1;
    u_if.in_data  = c;
    step();
    u_if.in_valid = 1'b0;
`else
    u_if.in_data  = c;
`endif
  endtask

  task automatic read_at(input logic [18:0] a);
    u_if.read_address = a;
    step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", u_if.in_ready); end
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", u_if.load_busy); end
    checks++; if (u_if.load_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", u_if.load_done); end
    checks++; if (u_if.load_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", u_if.load_error); end
    checks++; if (u_if.data_bus !== 60'h0) begin errors++; $display("FAIL reset_data_bus got=%h want=0", u_if.data_bus); end
    Reset_n = 1'b1;
    step();
    step();
    checks++; if (u_if.data_bus !== 60'h0) begin errors++; $display("FAIL post_reset_data_bus got=%h want=0", u_if.data_bus); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL post_reset_in_ready got=%b want=0", u_if.in_ready); end
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b want=0", u_if.load_busy); end
  endtask

  task automatic test_bad_index();
    u_if.load_start = 1'b1;
    u_if.load_frame = 4'd15;
    step();
    u_if.load_start = 1'b0;
    checks++; if (u_if.load_error !== 1'b1) begin errors++; $display("FAIL bad_idx_error got=%b want=1", u_if.load_error); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL bad_idx_in_ready got=%b want=0", u_if.in_ready); end
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL bad_idx_busy got=%b want=0", u_if.load_busy); end
    step();
    checks++; if (u_if.load_error !== 1'b0) begin errors++; $display("FAIL bad_idx_error_pulse got=%b want=0", u_if.load_error); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL bad_idx_in_ready2 got=%b want=0", u_if.in_ready); end
  endtask

  task automatic test_full_load();
    int acc, early;
    logic [7:0] sum;
    start_load(4'd2);
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready got=%b want=1", u_if.in_ready); end
    checks++; if (u_if.load_busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b want=1", u_if.load_busy); end
    feed(8'h5A, FP / 2, 1'b0, acc, early, sum);
    finish_csum(sum);
    checks++; if (early !== 0) begin errors++; $display("FAIL full_early_done got=%0d want=0", early); end
    checks++; if (u_if.load_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b want=1", u_if.load_done); end
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL full_done_busy got=%b want=0", u_if.load_busy); end
    step();
    checks++; if (u_if.load_done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got=%b want=0", u_if.load_done); end
    read_at(19'd0);
    checks++; if (u_if.data_bus[11:8] !== 4'hA) begin errors++; $display("FAIL full_rd0 got=%h want=a", u_if.data_bus[11:8]); end
    u_if.read_address = 19'd1;
    #1;
    checks++; if (u_if.data_bus[11:8] !== 4'hA) begin errors++; $display("FAIL full_rd_latency got=%h want=a", u_if.data_bus[11:8]); end
    step();
    checks++; if (u_if.data_bus[11:8] !== 4'h5) begin errors++; $display("FAIL full_rd1 got=%h want=5", u_if.data_bus[11:8]); end
    read_at(19'd6399);
    checks++; if (u_if.data_bus[11:8] !== 4'h5) begin errors++; $display("FAIL full_rd6399 got=%h want=5", u_if.data_bus[11:8]); end
  endtask

  task automatic test_abort();
    int acc, early;
    logic [7:0] sum;
    start_load(4'd0);
    feed(8'h33, FP / 2, 1'b0, acc, early, sum);
    finish_csum(sum);
    step();
    start_load(4'd0);
    feed(8'hC7, 100, 1'b0, acc, early, sum);
    u_if.in_valid   = 1'b1;
    u_if.in_data    = 8'hC7;
    u_if.load_abort = 1'b1;
    step();
    u_if.in_valid   = 1'b0;
    u_if.load_abort = 1'b0;
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", u_if.load_busy); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b want=0", u_if.in_ready); end
    checks++; if (u_if.load_done !== 1'b0 || u_if.load_error !== 1'b0) begin errors++; $display("FAIL abort_pulse got=%b%b want=00", u_if.load_done, u_if.load_error); end
    step();
    checks++; if (u_if.load_done !== 1'b0 || u_if.load_error !== 1'b0) begin errors++; $display("FAIL abort_pulse2 got=%b%b want=00", u_if.load_done, u_if.load_error); end
    read_at(19'd0);
    checks++; if (u_if.data_bus[3:0] !== 4'h7) begin errors++; $display("FAIL abort_rd0 got=%h want=7", u_if.data_bus[3:0]); end
    read_at(19'd199);
    checks++; if (u_if.data_bus[3:0] !== 4'hC) begin errors++; $display("FAIL abort_rd199 got=%h want=c", u_if.data_bus[3:0]); end
    read_at(19'd200);
    checks++; if (u_if.data_bus[3:0] !== 4'h3) begin errors++; $display("FAIL abort_rd200 got=%h want=3", u_if.data_bus[3:0]); end
    read_at(19'd201);
    checks++; if (u_if.data_bus[3:0] !== 4'h3) begin errors++; $display("FAIL abort_rd201 got=%h want=3", u_if.data_bus[3:0]); end
  endtask

  task automatic test_collision();
    start_load(4'd0);
    u_if.read_address = 19'd0;
    u_if.in_valid     = 1'b1;
    u_if.in_data      = 8'hE1;
    step();
    u_if.in_valid     = 1'b0;
    checks++; if (u_if.data_bus[3:0] !== 4'h7) begin errors++; $display("FAIL collide_old got=%h want=7", u_if.data_bus[3:0]); end
    step();
    checks++; if (u_if.data_bus[3:0] !== 4'h1) begin errors++; $display("FAIL collide_new got=%h want=1", u_if.data_bus[3:0]); end
    read_at(19'd1);
    checks++; if (u_if.data_bus[3:0] !== 4'hE) begin errors++; $display("FAIL collide_odd got=%h want=e", u_if.data_bus[3:0]); end
    u_if.load_abort = 1'b1;
    step();
    u_if.load_abort = 1'b0;
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL collide_abort_busy got=%b want=0", u_if.load_busy); end
  endtask

  task automatic test_backpressure();
    int acc, early;
    logic [7:0] sum;
    start_load(4'd3);
    feed(8'h96, FP / 2, 1'b1, acc, early, sum);
    finish_csum(sum);
    checks++; if (early !== 0) begin errors++; $display("FAIL bp_early_done got=%0d want=0", early); end
    checks++; if (u_if.load_done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b want=1", u_if.load_done); end
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'hFF;
    step();
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_extra_ready got=%b want=0", u_if.in_ready); end
    step();
    u_if.in_valid = 1'b0;
    read_at(19'd0);
    checks++; if (u_if.data_bus[15:12] !== 4'h6) begin errors++; $display("FAIL bp_rd0 got=%h want=6", u_if.data_bus[15:12]); end
    read_at(19'd6399);
    checks++; if (u_if.data_bus[15:12] !== 4'h9) begin errors++; $display("FAIL bp_rd6399 got=%h want=9", u_if.data_bus[15:12]); end
    checks++; if (u_if.data_bus[11:8] !== 4'h5) begin errors++; $display("FAIL bp_other_bank got=%h want=5", u_if.data_bus[11:8]); end
  endtask

  task automatic test_read_bounds();
    read_at(19'd6400);
    checks++; if (u_if.data_bus !== 60'h0) begin errors++; $display("FAIL rd_6400 got=%h want=0", u_if.data_bus); end
    read_at(19'h7FFFF);
    checks++; if (u_if.data_bus !== 60'h0) begin errors++; $display("FAIL rd_7ffff got=%h want=0", u_if.data_bus); end
    read_at(19'h02000);
    checks++; if (u_if.data_bus !== 60'h0) begin errors++; $display("FAIL rd_alias got=%h want=0", u_if.data_bus); end
    read_at(19'd6398);
    checks++; if (u_if.data_bus[11:8] !== 4'hA) begin errors++; $display("FAIL rd_6398 got=%h want=a", u_if.data_bus[11:8]); end
  endtask

  task automatic test_reset_midload();
    int acc, early;
    logic [7:0] sum;
    start_load(4'd5);
    feed(8'h11, 10, 1'b0, acc, early, sum);
    Reset_n = 1'b0;
    #2;
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", u_if.load_busy); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got=%b want=0", u_if.in_ready); end
    step();
    Reset_n = 1'b1;
    step();
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL midreset_after got=%b want=0", u_if.load_busy); end
  endtask

`ifdef SPRITE_CHECKSUM_EN
  task automatic test_checksum();
    int acc, early;
    logic [7:0] sum;
    start_load(4'd4);
    feed(8'h01, FP / 2, 1'b0, acc, early, sum);
    checks++; if (u_if.in_ready !== 1'b1 || u_if.load_done !== 1'b0) begin errors++; $display("FAIL csum_check_state got=%b%b want=10", u_if.in_ready, u_if.load_done); end
    finish_csum(8'h80);
    checks++; if (u_if.load_done !== 1'b1) begin errors++; $display("FAIL csum_good_done got=%b want=1", u_if.load_done); end
    checks++; if (u_if.load_error !== 1'b0) begin errors++; $display("FAIL csum_good_error got=%b want=0", u_if.load_error); end
    step();
    start_load(4'd4);
    feed(8'h01, FP / 2, 1'b0, acc, early, sum);
    finish_csum(8'h81);
    checks++; if (u_if.load_error !== 1'b1) begin errors++; $display("FAIL csum_bad_error got=%b want=1", u_if.load_error); end
    checks++; if (u_if.load_done !== 1'b0) begin errors++; $display("FAIL csum_bad_done got=%b want=0", u_if.load_done); end
    checks++; if (u_if.load_busy !== 1'b0) begin errors++; $display("FAIL csum_bad_busy got=%b want=0", u_if.load_busy); end
    step();
    checks++; if (u_if.load_error !== 1'b0 || u_if.load_done !== 1'b0) begin errors++; $display("FAIL csum_bad_pulse got=%b%b want=00", u_if.load_error, u_if.load_done); end
  endtask
`endif

  initial begin
    u_if.load_start   = 1'b0;
    u_if.load_frame   = 4'd0;
    u_if.load_abort   = 1'b0;
    u_if.in_data      = 8'h00;
    u_if.in_valid     = 1'b0;
    u_if.read_address = 19'h7FFFF;
    test_reset();
    test_bad_index();
    test_full_load();
    test_abort();
    test_collision();
    test_backpressure();
    test_read_bounds();
    test_reset_midload();
`ifdef SPRITE_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
